// File: rtl/isl51002_pkg.sv
// Shared definitions for the ISL51002 mode controller.
//   lock_state_e : input-sync lock states, encoding visible on lock_state_o
//   CfgAddr*     : shadow register addresses on the CPU config bus
//   Ctrl*        : bit positions inside the ctrl register (address 3)
package isl51002_pkg;

  typedef enum logic [1:0] {
    LkNoSync  = 2'd0,
    LkAcquire = 2'd1,
    LkLocked  = 2'd2,
    LkHold    = 2'd3
  } lock_state_e;

  localparam logic [1:0] CfgAddrHv   = 2'd0;
  localparam logic [1:0] CfgAddrHv2  = 2'd1;
  localparam logic [1:0] CfgAddrHv3  = 2'd2;
  localparam logic [1:0] CfgAddrCtrl = 2'd3;

  localparam int unsigned CtrlVsType = 0;
  localparam int unsigned CtrlVsPol  = 1;
  localparam int unsigned CtrlCscEn  = 2;
  localparam int unsigned CtrlCscCs  = 3;
  localparam int unsigned CtrlW      = 4;

endpackage

// File: rtl/isl51002_mode_ctrl_if.sv
// CPU-side config bus of the ISL51002 mode controller.
//   cfg_wr / cfg_addr / cfg_data : shadow register write
//   cfg_commit                   : request to apply the shadow set
//   commit_pending               : commit requested, not yet applied
//   commit_done                  : 1-cycle pulse, new active config visible
interface isl51002_mode_ctrl_if;
  logic        cfg_wr;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic        cfg_commit;
  logic        commit_pending;
  logic        commit_done;

  modport master (
    output cfg_wr, cfg_addr, cfg_data, cfg_commit,
    input  commit_pending, commit_done
  );

  modport slave (
    input  cfg_wr, cfg_addr, cfg_data, cfg_commit,
    output commit_pending, commit_done
  );
endinterface

// File: rtl/isl51002_lock_fsm.sv
// Input-sync lock tracker for the ISL51002 frontend.
// Ports:
//   PCLK_i, reset_n      : pixel clock, async active-low reset
//   fe_i                 : frame edge (rising edge of frame_change)
//   apply_i              : shadow config applied this cycle; outside NO_SYNC
//                          restarts acquisition
//   vtotal_i, interlace_i: frontend measured timing
//   state_o              : lock state
//   vtotal_ref_o         : reference vtotal
//   mode_change_o        : 1-cycle pulse on loss of lock
module isl51002_lock_fsm
  import isl51002_pkg::*;
#(
  parameter int unsigned LOCK_FRAMES   = 3,
  parameter int unsigned UNLOCK_FRAMES = 2,
  parameter int unsigned VTOTAL_TOL    = 1,
  parameter logic [23:0] FRAME_TIMEOUT = 24'd4000000
) (
  input  logic        PCLK_i,
  input  logic        reset_n,
  input  logic        fe_i,
  input  logic        apply_i,
  input  logic [10:0] vtotal_i,
  input  logic        interlace_i,
  output lock_state_e state_o,
  output logic [10:0] vtotal_ref_o,
  output logic        mode_change_o
);

  lock_state_e state_q;
  logic [10:0] ref_q;
  logic        iref_q;
  logic [7:0]  match_cnt_q;
  logic [7:0]  miss_cnt_q;
  logic [23:0] tmo_q;
  logic        mode_change_q;

  logic signed [11:0] diff;
  logic [11:0]        diff_abs;
  logic               match;
  logic [7:0]         match_inc;
  logic [7:0]         miss_inc;
  logic               timeout_hit;

  always_comb begin
    // 12-bit signed difference cannot wrap for 11-bit operands
    diff        = $signed({1'b0, vtotal_i}) - $signed({1'b0, ref_q});
    diff_abs    = diff[11] ? 12'(-diff) : 12'(diff);
    match       = (diff_abs <= 12'(VTOTAL_TOL)) && (interlace_i == iref_q);
    match_inc   = match_cnt_q + 8'd1;
    miss_inc    = miss_cnt_q + 8'd1;
    // Fires once, on the cycle the counter would reach the limit; fe wins
    timeout_hit = !fe_i && (tmo_q == FRAME_TIMEOUT - 24'd1);
  end

  always_ff @(posedge PCLK_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= LkNoSync;
      ref_q         <= '0;
      iref_q        <= 1'b0;
      match_cnt_q   <= '0;
      miss_cnt_q    <= '0;
      tmo_q         <= '0;
      mode_change_q <= 1'b0;
    end else begin
      mode_change_q <= 1'b0;

      if (fe_i) begin
        tmo_q <= '0;
      end else if (tmo_q != FRAME_TIMEOUT) begin
        tmo_q <= tmo_q + 24'd1;
      end

      if (fe_i) begin
        if (apply_i && state_q != LkNoSync) begin
          // New config invalidates the measured timing; restart from scratch
          state_q     <= LkAcquire;
          match_cnt_q <= '0;
          miss_cnt_q  <= '0;
        end else begin
          unique case (state_q)
            LkNoSync: begin
              state_q     <= LkAcquire;
              ref_q       <= vtotal_i;
              iref_q      <= interlace_i;
              match_cnt_q <= 8'd1;
            end
            LkAcquire: begin
              if (match_cnt_q == 8'd0 || !match) begin
                ref_q       <= vtotal_i;
                iref_q      <= interlace_i;
                match_cnt_q <= 8'd1;
              end else begin
                match_cnt_q <= match_inc;
                if ({24'd0, match_inc} >= LOCK_FRAMES) state_q <= LkLocked;
              end
            end
            LkLocked: begin
              if (!match) begin
                state_q    <= LkHold;
                miss_cnt_q <= 8'd1;
              end
            end
            LkHold: begin
              if (match) begin
                state_q    <= LkLocked;
                miss_cnt_q <= '0;
              end else if ({24'd0, miss_inc} >= UNLOCK_FRAMES) begin
                state_q       <= LkAcquire;
                ref_q         <= vtotal_i;
                iref_q        <= interlace_i;
                match_cnt_q   <= 8'd1;
                miss_cnt_q    <= '0;
                mode_change_q <= 1'b1;
              end else begin
                miss_cnt_q <= miss_inc;
              end
            end
            default: state_q <= LkNoSync;
          endcase
        end
      end else if (timeout_hit) begin
        // References are kept; only the lock progress is discarded
        state_q       <= LkNoSync;
        match_cnt_q   <= '0;
        miss_cnt_q    <= '0;
        mode_change_q <= (state_q == LkLocked) || (state_q == LkHold);
      end
    end
  end

  assign state_o       = state_q;
  assign vtotal_ref_o  = ref_q;
  assign mode_change_o = mode_change_q;

endmodule

// File: rtl/isl51002_mode_ctrl.sv
// ISL51002 frontend mode controller: CPU-written shadow config applied
// atomically at a frame boundary, plus input-sync lock tracking.
// Ports:
//   PCLK_i, reset_n          : pixel clock, async active-low reset
//   cfg                      : CPU config bus (write, commit, status)
//   frame_change_i, vtotal_i,
//   interlace_flag_i         : frontend sync measurements
//   hv_in_config*_o, vs_*_o,
//   csc_*_o                  : active config to the frontend
//   lock_state_o, locked_o,
//   mode_change_o,
//   vtotal_ref_o             : lock status to the CPU
module isl51002_mode_ctrl
  import isl51002_pkg::*;
#(
  parameter int unsigned LOCK_FRAMES   = 3,
  parameter int unsigned UNLOCK_FRAMES = 2,
  parameter int unsigned VTOTAL_TOL    = 1,
  parameter logic [23:0] FRAME_TIMEOUT = 24'd4000000
) (
  input  logic                       PCLK_i,
  input  logic                       reset_n,
  isl51002_mode_ctrl_if.slave        cfg,
  input  logic                       frame_change_i,
  input  logic [10:0]                vtotal_i,
  input  logic                       interlace_flag_i,
  output logic [31:0]                hv_in_config_o,
  output logic [31:0]                hv_in_config2_o,
  output logic [31:0]                hv_in_config3_o,
  output logic                       vs_type_o,
  output logic                       vs_polarity_o,
  output logic                       csc_enable_o,
  output logic                       csc_cs_o,
  output logic [1:0]                 lock_state_o,
  output logic                       locked_o,
  output logic                       mode_change_o,
  output logic [10:0]                vtotal_ref_o
);

  logic             fc_prev_q;
  logic [31:0]      sh_hv_q, sh_hv2_q, sh_hv3_q;
  logic [CtrlW-1:0] sh_ctrl_q;
  logic [31:0]      act_hv_q, act_hv2_q, act_hv3_q;
  logic [CtrlW-1:0] act_ctrl_q;
  logic             pending_q;
  logic             done_q;

  logic        fe;
  logic        apply;
  lock_state_e lock_state;

  assign fe    = frame_change_i & ~fc_prev_q;
  // Commits apply at a frame edge, or immediately when there is no sync
  assign apply = (pending_q | cfg.cfg_commit) & (fe | (lock_state == LkNoSync));

  always_ff @(posedge PCLK_i or negedge reset_n) begin
    if (!reset_n) begin
      fc_prev_q  <= 1'b0;
      sh_hv_q    <= '0;
      sh_hv2_q   <= '0;
      sh_hv3_q   <= '0;
      sh_ctrl_q  <= '0;
      act_hv_q   <= '0;
      act_hv2_q  <= '0;
      act_hv3_q  <= '0;
      act_ctrl_q <= '0;
      pending_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      fc_prev_q <= frame_change_i;
      done_q    <= apply;

      if (cfg.cfg_wr) begin
        unique case (cfg.cfg_addr)
          CfgAddrHv:   sh_hv_q   <= cfg.cfg_data;
          CfgAddrHv2:  sh_hv2_q  <= cfg.cfg_data;
          CfgAddrHv3:  sh_hv3_q  <= cfg.cfg_data;
          CfgAddrCtrl: sh_ctrl_q <= cfg.cfg_data[CtrlW-1:0];
          default:     sh_hv_q   <= sh_hv_q;
        endcase
      end

      // Non-blocking reads give the shadow value from before a same-cycle write
      if (apply) begin
        act_hv_q   <= sh_hv_q;
        act_hv2_q  <= sh_hv2_q;
        act_hv3_q  <= sh_hv3_q;
        act_ctrl_q <= sh_ctrl_q;
        pending_q  <= 1'b0;
      end else if (cfg.cfg_commit) begin
        pending_q <= 1'b1;
      end
    end
  end

  isl51002_lock_fsm #(
    .LOCK_FRAMES  (LOCK_FRAMES),
    .UNLOCK_FRAMES(UNLOCK_FRAMES),
    .VTOTAL_TOL   (VTOTAL_TOL),
    .FRAME_TIMEOUT(FRAME_TIMEOUT)
  ) u_lock_fsm (
    .PCLK_i       (PCLK_i),
    .reset_n      (reset_n),
    .fe_i         (fe),
    .apply_i      (apply),
    .vtotal_i     (vtotal_i),
    .interlace_i  (interlace_flag_i),
    .state_o      (lock_state),
    .vtotal_ref_o (vtotal_ref_o),
    .mode_change_o(mode_change_o)
  );

  assign hv_in_config_o     = act_hv_q;
  assign hv_in_config2_o    = act_hv2_q;
  assign hv_in_config3_o    = act_hv3_q;
  assign vs_type_o          = act_ctrl_q[CtrlVsType];
  assign vs_polarity_o      = act_ctrl_q[CtrlVsPol];
  assign csc_enable_o       = act_ctrl_q[CtrlCscEn];
  assign csc_cs_o           = act_ctrl_q[CtrlCscCs];
  assign cfg.commit_pending = pending_q;
  assign cfg.commit_done    = done_q;
  assign lock_state_o       = lock_state;
  assign locked_o           = (lock_state == LkLocked) || (lock_state == LkHold);

endmodule

// File: tb/tb_isl51002_mode_ctrl.sv
// Bench for isl51002_mode_ctrl: directed scenarios followed by randomized
// frames, all checked against a frame-level reference model.
module tb_isl51002_mode_ctrl;

  localparam int Tmo = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_change = 1'b0;
  logic [10:0] vtotal = '0;
  logic        interlace = 1'b0;
  logic [31:0] hv0, hv1, hv2;
  logic        vs_type, vs_pol, csc_en, csc_cs;
  logic [1:0]  lock_state;
  logic        locked, mode_change;
  logic [10:0] vtotal_ref;

  int errors = 0;
  int checks = 0;

  isl51002_mode_ctrl_if bus ();

  always #5 clk = ~clk;

  isl51002_mode_ctrl #(
    .LOCK_FRAMES  (3),
    .UNLOCK_FRAMES(2),
    .VTOTAL_TOL   (1),
    .FRAME_TIMEOUT(24'(Tmo))
  ) dut (
    .PCLK_i          (clk),
    .reset_n         (rst_n),
    .cfg             (bus),
    .frame_change_i  (frame_change),
    .vtotal_i        (vtotal),
    .interlace_flag_i(interlace),
    .hv_in_config_o  (hv0),
    .hv_in_config2_o (hv1),
    .hv_in_config3_o (hv2),
    .vs_type_o       (vs_type),
    .vs_polarity_o   (vs_pol),
    .csc_enable_o    (csc_en),
    .csc_cs_o        (csc_cs),
    .lock_state_o    (lock_state),
    .locked_o        (locked),
    .mode_change_o   (mode_change),
    .vtotal_ref_o    (vtotal_ref)
  );

  // Reference model: 0 NO_SYNC, 1 ACQUIRE, 2 LOCKED, 3 HOLD
  int          m_st, m_mc, m_miss, m_ref;
  bit          m_iref, m_pend, m_done, m_modechg;
  logic [31:0] m_sh[4];
  logic [31:0] m_act[4];

  task automatic model_reset();
    m_st = 0; m_mc = 0; m_miss = 0; m_ref = 0; m_iref = 0;
    m_pend = 0; m_done = 0; m_modechg = 0;
    for (int i = 0; i < 4; i++) begin
      m_sh[i] = '0;
      m_act[i] = '0;
    end
  endtask

  task automatic model_wr(input logic [1:0] a, input logic [31:0] d);
    m_sh[a] = (a == 2'd3) ? (d & 32'hF) : d;
  endtask

  task automatic model_fe(input int vt, input bit il, input bit commit_now);
    bit apply;
    int d;
    bit good;
    apply = m_pend || commit_now;
    m_done = apply;
    m_modechg = 0;
    if (apply) begin
      for (int i = 0; i < 4; i++) m_act[i] = m_sh[i];
      m_pend = 0;
    end
    d = vt - m_ref;
    if (d < 0) d = -d;
    good = (d <= 1) && (il == m_iref);
    if (m_st == 0) begin
      m_st = 1; m_ref = vt; m_iref = il; m_mc = 1;
    end else if (apply) begin
      m_st = 1; m_mc = 0; m_miss = 0;
    end else if (m_st == 1) begin
      if (m_mc == 0 || !good) begin
        m_ref = vt; m_iref = il; m_mc = 1;
      end else begin
        m_mc++;
        if (m_mc >= 3) m_st = 2;
      end
    end else if (m_st == 2) begin
      if (!good) begin
        m_st = 3; m_miss = 1;
      end
    end else begin
      if (good) begin
        m_st = 2; m_miss = 0;
      end else if (m_miss + 1 >= 2) begin
        m_st = 1; m_ref = vt; m_iref = il; m_mc = 1; m_miss = 0; m_modechg = 1;
      end else begin
        m_miss++;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_hv0"}, hv0, m_act[0]);
    chk({tag, "_hv1"}, hv1, m_act[1]);
    chk({tag, "_hv2"}, hv2, m_act[2]);
    chk({tag, "_ctrl"}, {28'd0, csc_cs, csc_en, vs_pol, vs_type}, m_act[3]);
    chk({tag, "_state"}, 32'(lock_state), 32'(m_st));
    chk({tag, "_ref"}, 32'(vtotal_ref), 32'(m_ref));
    chk({tag, "_locked"}, 32'(locked), 32'(m_st >= 2));
    chk({tag, "_pending"}, 32'(bus.commit_pending), 32'(m_pend));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic write(input logic [1:0] a, input logic [31:0] d);
    bus.cfg_wr = 1'b1; bus.cfg_addr = a; bus.cfg_data = d;
    model_wr(a, d);
    tick();
    bus.cfg_wr = 1'b0;
  endtask

  task automatic commit_mid(input string tag);
    bus.cfg_commit = 1'b1;
    m_done = 0;
    if (m_st == 0) begin
      for (int i = 0; i < 4; i++) m_act[i] = m_sh[i];
      m_pend = 0;
      m_done = 1;
    end else begin
      m_pend = 1;
    end
    tick();
    bus.cfg_commit = 1'b0;
    check_all(tag);
    chk({tag, "_done"}, 32'(bus.commit_done), 32'(m_done));
  endtask

  // One frame: fe on the first cycle, frame_change held high for 3 cycles
  task automatic frame(input string tag, input int vt, input bit il, input bit commit_now,
                       input bit wr_now, input logic [1:0] wa, input logic [31:0] wd);
    frame_change = 1'b1; vtotal = 11'(vt); interlace = il;
    bus.cfg_commit = commit_now; bus.cfg_wr = wr_now; bus.cfg_addr = wa; bus.cfg_data = wd;
    model_fe(vt, il, commit_now);
    if (wr_now) model_wr(wa, wd);
    tick();
    bus.cfg_commit = 1'b0; bus.cfg_wr = 1'b0;
    check_all(tag);
    chk({tag, "_done"}, 32'(bus.commit_done), 32'(m_done));
    chk({tag, "_modechg"}, 32'(mode_change), 32'(m_modechg));
    idle(2);
    frame_change = 1'b0;
    chk({tag, "_done_clr"}, 32'(bus.commit_done), 32'd0);
    chk({tag, "_modechg_clr"}, 32'(mode_change), 32'd0);
  endtask

  initial begin
    int n;
    int vt;
    bit il;
    bus.cfg_wr = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0; bus.cfg_commit = 1'b0;
    model_reset();

    // Reset state
    idle(3);
    check_all("rst");
    chk("rst_done", 32'(bus.commit_done), 32'd0);
    chk("rst_modechg", 32'(mode_change), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Commit in NO_SYNC applies without a frame edge
    write(2'd0, 32'h1234_5678);
    write(2'd1, 32'h0000_1111);
    write(2'd2, 32'h0000_2222);
    write(2'd3, 32'hFFFF_FFF5);
    chk("shadow_not_active", hv0, 32'd0);
    commit_mid("nosync_commit");
    chk("nosync_hv0", hv0, 32'h1234_5678);
    chk("nosync_done", 32'(bus.commit_done), 32'd1);
    tick();
    chk("nosync_done_pulse", 32'(bus.commit_done), 32'd0);

    // Acquire and lock on 525
    frame("acq1", 525, 0, 0, 0, 0, 0);
    chk("acq1_state", 32'(lock_state), 32'd1);
    idle(3);
    frame("acq2", 525, 0, 0, 0, 0, 0);
    idle(3);
    frame("acq3", 525, 0, 0, 0, 0, 0);
    chk("lock_state", 32'(lock_state), 32'd2);
    chk("lock_ref", 32'(vtotal_ref), 32'd525);
    chk("lock_locked", 32'(locked), 32'd1);

    // Tolerance, HOLD, then loss of lock
    idle(3);
    frame("tol", 526, 0, 0, 0, 0, 0);
    chk("tol_stay", 32'(lock_state), 32'd2);
    idle(3);
    frame("hold", 530, 0, 0, 0, 0, 0);
    chk("hold_state", 32'(lock_state), 32'd3);
    idle(3);
    frame("unlock", 530, 0, 0, 0, 0, 0);
    chk("unlock_state", 32'(lock_state), 32'd1);
    chk("unlock_ref", 32'(vtotal_ref), 32'd530);
    for (int k = 0; k < 2; k++) begin
      idle(3);
      frame("relock", 530, 0, 0, 0, 0, 0);
    end
    chk("relock_state", 32'(lock_state), 32'd2);

    // Mid-frame commit while LOCKED waits for the next edge
    write(2'd1, 32'hCAFE_0001);
    commit_mid("mid_commit");
    chk("mid_pending", 32'(bus.commit_pending), 32'd1);
    idle(4);
    chk("mid_hold_hv1", hv1, 32'h0000_1111);
    frame("mid_apply", 530, 0, 0, 0, 0, 0);
    chk("mid_apply_hv1", hv1, 32'hCAFE_0001);
    chk("mid_apply_state", 32'(lock_state), 32'd1);
    chk("mid_apply_pending", 32'(bus.commit_pending), 32'd0);

    // Commit + fe + write in one cycle: old shadow goes active
    write(2'd0, 32'hAAAA_0001);
    frame("same_cyc", 530, 0, 1, 1, 2'd0, 32'hBBBB_0002);
    chk("same_cyc_hv0", hv0, 32'hAAAA_0001);
    chk("same_cyc_pending", 32'(bus.commit_pending), 32'd0);
    commit_mid("same_cyc_recommit");
    idle(2);
    frame("shadow_only", 530, 0, 0, 0, 0, 0);
    chk("shadow_only_hv0", hv0, 32'hBBBB_0002);

    // Randomized frames
    for (int f = 0; f < 40; f++) begin
      n = int'($urandom_range(0, 9));
      if (n < 6) vt = m_ref + int'($urandom_range(0, 2)) - 1;
      else if (n < 8) vt = ($urandom_range(0, 1) == 0) ? m_ref + 3 : m_ref - 3;
      else vt = int'($urandom_range(200, 1000));
      il = ($urandom_range(0, 7) == 0) ? !m_iref : m_iref;
      if ($urandom_range(0, 2) == 0) write(2'($urandom_range(0, 3)), $urandom);
      if ($urandom_range(0, 3) == 0) commit_mid("rnd_commit");
      idle(int'($urandom_range(1, 5)));
      frame("rnd", vt, il, $urandom_range(0, 7) == 0, 0, 0, 0);
    end

    // Timeout from LOCKED
    for (int k = 0; k < 8 && m_st != 2; k++) begin
      idle(2);
      frame("pre_tmo", m_ref, m_iref, 0, 0, 0, 0);
    end
    chk("pre_tmo_state", 32'(lock_state), 32'd2);
    n = 0;
    while (lock_state !== 2'd0 && n < 200) begin
      tick();
      n++;
    end
    m_st = 0; m_mc = 0; m_miss = 0;
    chk("tmo_cycles", 32'(n), 32'(Tmo - 2));
    chk("tmo_modechg", 32'(mode_change), 32'd1);
    check_all("tmo");
    tick();
    chk("tmo_modechg_pulse", 32'(mode_change), 32'd0);

    // Reset with a commit pending
    frame("pre_rst", 600, 1, 0, 0, 0, 0);
    write(2'd2, 32'h5555_AAAA);
    commit_mid("pre_rst_commit");
    chk("pre_rst_pending", 32'(bus.commit_pending), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("mid_rst");
    chk("mid_rst_done", 32'(bus.commit_done), 32'd0);
    chk("mid_rst_modechg", 32'(mode_change), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
